// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: buffers A and B,
// clears the PEs, feeds skewed rows/columns on the west/north edges, drains.

module systolic_lane_sel #(
  parameter int DATA_SIZE = 4,
  parameter int N         = 3,
  parameter int TW        = 3,
  parameter int LANE      = 0
) (
  input  logic                        feed,
  input  logic [TW-1:0]               t,
  input  logic [N-1:0][DATA_SIZE-1:0] vec,
  output logic [DATA_SIZE-1:0]        val
);
  // Lane LANE is delayed LANE cycles: element k appears when t == k + LANE.
  always_comb begin
    val = '0;
    if (feed)
      for (int k = 0; k < N; k++)
        if (t == TW'(k + LANE)) val = vec[k];
  end
endmodule

module systolic_seq_ctrl #(
  parameter int DATA_SIZE = 4,
  parameter int N         = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [$clog2(N):0]       ld_row,
  input  logic [$clog2(N):0]       ld_col,
  input  logic [DATA_SIZE-1:0]     ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     res_valid,
  output logic                     arr_clr,
  output logic [N*DATA_SIZE-1:0]   arr_a,
  output logic [N*DATA_SIZE-1:0]   arr_b
);
  localparam int RW = $clog2(N) + 1;
  localparam int TW = $clog2(2*N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t  state, state_nxt;
  logic [TW-1:0] t, t_nxt;

  logic [N-1:0][N-1:0][DATA_SIZE-1:0] buf_a, buf_b;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0] col_b;
  logic [N-1:0][DATA_SIZE-1:0]        lane_a_nxt, lane_b_nxt;
  logic [N-1:0][DATA_SIZE-1:0]        lane_a, lane_b;
  logic                               feed_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_CLEAR;
        t_nxt     = '0;
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        t_nxt     = '0;
      end
      S_FEED: begin
        if (t == TW'(2*N-2)) begin
          state_nxt = (N == 1) ? S_DONE : S_DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (int'(t) >= N-2) begin
          state_nxt = S_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = start ? S_CLEAR : S_IDLE;
        t_nxt     = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  assign busy    = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
  assign done    = (state == S_DONE);
  assign arr_clr = reset || (state == S_CLEAR);

  // Results stay valid in IDLE until the next run starts clearing the array.
  always_ff @(posedge clk) begin
    if (reset)                     res_valid <= 1'b0;
    else if (state_nxt == S_DONE)  res_valid <= 1'b1;
    else if (state_nxt == S_CLEAR) res_valid <= 1'b0;
  end

  // Out-of-range indices never match a row/column, so they are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_a <= '0;
      buf_b <= '0;
    end else if (ld_en && !busy) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (ld_row == RW'(r) && ld_col == RW'(c)) begin
            if (ld_sel) buf_b[r][c] <= ld_data;
            else        buf_a[r][c] <= ld_data;
          end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        col_b[c][r] = buf_b[r][c];
  end

  // Lanes are computed from the next state so the registered value lines
  // up with the cycle tagged by state/t.
  assign feed_nxt = (state_nxt == S_FEED);

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_lane_sel #(.DATA_SIZE(DATA_SIZE), .N(N), .TW(TW), .LANE(i)) u_a (
      .feed (feed_nxt),
      .t    (t_nxt),
      .vec  (buf_a[i]),
      .val  (lane_a_nxt[i])
    );
    systolic_lane_sel #(.DATA_SIZE(DATA_SIZE), .N(N), .TW(TW), .LANE(i)) u_b (
      .feed (feed_nxt),
      .t    (t_nxt),
      .vec  (col_b[i]),
      .val  (lane_b_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_a <= '0;
      lane_b <= '0;
    end else begin
      lane_a <= lane_a_nxt;
      lane_b <= lane_b_nxt;
    end
  end

  assign arr_a = lane_a;
  assign arr_b = lane_b;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed tables/sequences plus random traffic,
// checked against a cycle-count model and an emulated PE array.

module tb_systolic_seq_ctrl;
  localparam int DS  = 4;
  localparam int N   = 3;
  localparam int RW  = $clog2(N) + 1;
  localparam int LAT = 3 * N;

  logic clk = 1'b0;
  logic reset = 1'b1, ld_en = 1'b0, ld_sel = 1'b0, start = 1'b0;
  logic [RW-1:0] ld_row = '0, ld_col = '0;
  logic [DS-1:0] ld_data = '0;
  logic busy, done, res_valid, arr_clr;
  logic [N*DS-1:0] arr_a, arr_b;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.DATA_SIZE(DS), .N(N)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start),
    .busy(busy), .done(done), .res_valid(res_valid), .arr_clr(arr_clr),
    .arr_a(arr_a), .arr_b(arr_b)
  );

  int nvec = 0, nerr = 0;
  int ma[N][N], mb[N][N];
  int mcyc = 0;
  bit mres = 0;
  int acc[N][N], ar[N][N], br[N][N];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // mcyc counts cycles since the start edge: 1 CLEAR, 2..2N FEED, then DRAIN, LAT = DONE.
  function automatic logic [N*DS-1:0] exp_lanes(bit is_a);
    logic [N*DS-1:0] v;
    int t, k;
    v = '0;
    if (mcyc >= 2 && mcyc <= 2*N) begin
      t = mcyc - 2;
      for (int i = 0; i < N; i++) begin
        k = t - i;
        if (k >= 0 && k < N) v[i*DS +: DS] = DS'(is_a ? ma[i][k] : mb[k][i]);
      end
    end
    return v;
  endfunction

  task automatic model_edge();
    bit b;
    b = (mcyc >= 1 && mcyc < LAT);
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
      mcyc = 0;
      mres = 0;
    end else begin
      if (!b && ld_en && ld_row < N && ld_col < N) begin
        if (ld_sel) mb[ld_row][ld_col] = $signed(ld_data);
        else        ma[ld_row][ld_col] = $signed(ld_data);
      end
      if (mcyc == 0) begin
        if (start) begin mcyc = 1; mres = 0; end
      end else if (mcyc == LAT) begin
        mcyc = start ? 1 : 0;
        if (start) mres = 0;
      end else begin
        mcyc++;
        if (mcyc == LAT) mres = 1;
      end
    end
  endtask

  // Output-stationary array: a moves east, b moves south, one cycle per PE.
  task automatic emu();
    int na[N][N], nb[N][N];
    int ain, bin;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ain = (j == 0) ? int'($signed(arr_a[i*DS +: DS])) : ar[i][j-1];
        bin = (i == 0) ? int'($signed(arr_b[j*DS +: DS])) : br[i-1][j];
        na[i][j] = ain;
        nb[i][j] = bin;
        if (arr_clr) acc[i][j] = 0;
        else         acc[i][j] += ain * bin;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ar[i][j] = arr_clr ? 0 : na[i][j];
        br[i][j] = arr_clr ? 0 : nb[i][j];
      end
  endtask

  task automatic step();
    int s;
    @(posedge clk);
    model_edge();
    #1;
    emu();
    chk("busy", 64'(busy), 64'(mcyc >= 1 && mcyc < LAT));
    chk("done", 64'(done), 64'(mcyc == LAT));
    chk("res_valid", 64'(res_valid), 64'(mres));
    chk("arr_clr", 64'(arr_clr), 64'(reset || mcyc == 1));
    chk("arr_a", 64'(arr_a), 64'(exp_lanes(1)));
    chk("arr_b", 64'(arr_b), 64'(exp_lanes(0)));
    if (mcyc == LAT)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s = 0;
          for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
          chk("c_prod", 64'(acc[i][j]), 64'(s));
        end
  endtask

  task automatic wr(bit s, int r, int c, int v);
    ld_en = 1'b1; ld_sel = s; ld_row = RW'(r); ld_col = RW'(c); ld_data = DS'(v);
    step();
    ld_en = 1'b0;
  endtask

  task automatic load(bit s, input int m[N][N]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wr(s, i, j, m[i][j]);
  endtask

  task automatic run(output int cyc);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  typedef struct { bit st; bit busy; bit done; bit clr; int l0; int l1; } vec_t;

  initial begin
    int eye[N][N], bm[N][N], m8[N][N], ra[N][N], rb[N][N];
    vec_t tbl[10];
    int cyc;
    tbl[0] = '{1, 1, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 0, 2, 4};
    tbl[3] = '{0, 1, 0, 0, 3, 5};
    tbl[4] = '{0, 1, 0, 0, 0, 6};
    tbl[5] = '{0, 1, 0, 0, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0};
    bm = '{'{1, 2, 3}, '{4, 5, 6}, '{7, -8, -1}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        eye[i][j] = (i == j) ? 1 : 0;
        m8[i][j]  = -8;
        acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
      end

    // Reset state
    do_reset();
    step();

    // Identity times B
    load(0, eye);
    load(1, bm);
    run(cyc);
    chk("t1_latency", 64'(cyc), 64'd9);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("t1_c_eq_b", 64'(acc[i][j]), 64'(bm[i][j]));

    // Lane skew table
    do_reset();
    for (int j = 0; j < N; j++) begin wr(0, 0, j, j + 1); wr(0, 1, j, j + 4); end
    for (int k = 0; k < 10; k++) begin
      start = tbl[k].st;
      step();
      start = 1'b0;
      chk("tbl_busy", 64'(busy), 64'(tbl[k].busy));
      chk("tbl_done", 64'(done), 64'(tbl[k].done));
      chk("tbl_clr", 64'(arr_clr), 64'(tbl[k].clr));
      chk("tbl_lane0", 64'(arr_a[DS-1:0]), 64'(DS'(tbl[k].l0)));
      chk("tbl_lane1", 64'(arr_a[2*DS-1:DS]), 64'(DS'(tbl[k].l1)));
    end

    // All -8 extremes, then results hold
    load(0, m8);
    load(1, m8);
    run(cyc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("t3_c192", 64'(acc[i][j]), 64'd192);
    repeat (10) step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("t3_hold", 64'(acc[i][j]), 64'd192);

    // Start and load during FEED are ignored
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ra[i][j] = $urandom_range(15) - 8;
        rb[i][j] = $urandom_range(15) - 8;
      end
    load(0, ra);
    load(1, rb);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    ld_en = 1'b1; ld_sel = 1'b0; ld_row = '0; ld_col = '0; ld_data = 4'd5; start = 1'b1;
    step(); step();
    ld_en = 1'b0; start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("t4_done", 64'(done), 64'd1);
    step();
    run(cyc);
    chk("t4_a00_kept", 64'(ma[0][0]), 64'(ra[0][0]));

    // Reset at FEED t=2
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    reset = 1'b1; step();
    chk("t5_clr_in_reset", 64'(arr_clr), 64'd1);
    reset = 1'b0; step();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_resv", 64'(res_valid), 64'd0);
    run(cyc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("t5_zero", 64'(acc[i][j]), 64'd0);

    // Back-to-back via start held through DONE; ld_row=N dropped
    load(0, eye);
    load(1, bm);
    wr(1, N, 0, 7);
    start = 1'b1; step();
    cyc = 1;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("t6_first", 64'(cyc), 64'd9);
    step();
    chk("t6_clear_next", 64'(arr_clr), 64'd1);
    cyc = 1;
    start = 1'b0;
    while (!done && cyc < 40) begin step(); cyc++; end
    chk("t6_second", 64'(cyc), 64'd9);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("t6_c_eq_b", 64'(acc[i][j]), 64'(bm[i][j]));

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      reset   = ($urandom_range(199) == 0);
      start   = ($urandom_range(9) == 0);
      ld_en   = ($urandom_range(1) == 1);
      ld_sel  = 1'($urandom_range(1));
      ld_row  = RW'($urandom_range((1 << RW) - 1));
      ld_col  = RW'($urandom_range((1 << RW) - 1));
      ld_data = DS'($urandom);
      step();
    end
    reset = 1'b0; start = 1'b0; ld_en = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
